// File: rtl/uart_tx_scheduler_if.sv
// CPU data-port and transmitter handshake bundle for uart_tx_scheduler.
// master drives CPU/memory/transmitter inputs; slave is the scheduler itself.
interface uart_tx_scheduler_if;
   logic        writeIn;
   logic        readIn;
   logic [31:0] addressIn;
   logic [31:0] dataIn;
   logic [31:0] memOutIn;
   logic        writeOut;
   logic        readOut;
   logic [31:0] memOutOut;
   logic [31:0] data;
   logic        start;
   logic        finish;

   modport master (
      output writeIn, readIn, addressIn, dataIn, memOutIn, finish,
      input  writeOut, readOut, memOutOut, data, start
   );

   modport slave (
      input  writeIn, readIn, addressIn, dataIn, memOutIn, finish,
      output writeOut, readOut, memOutOut, data, start
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Memory-mapped UART transmit scheduler: FIFO-queued stores drained over a start/finish handshake.
// Define TX_STATUS_READ_EN to make CPU loads from STATUS_ADDR return the status word.
module uart_tx_scheduler #(
   parameter int unsigned DEPTH       = 8,
   parameter logic [31:0] DATA_ADDR   = 32'h0000_0400,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_0404
) (
   input logic               clock,
   input logic               reset,
   uart_tx_scheduler_if.slave bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

   state_t          state_q, state_d;
   logic            start_q, start_d;
   logic [31:0]     data_q, data_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            sync1_q, sync2_q;
   logic [31:0]     mem_q [DEPTH];

   logic            dhit, shit, stat_rd_hit;
   logic            push_req, push_ok, pop;
   logic            full, empty, fsync;
   logic            ovf_set, ovf_clr;
   logic [31:0]     status;

   assign dhit = (bus.addressIn == DATA_ADDR);
   assign shit = (bus.addressIn == STATUS_ADDR);

`ifdef TX_STATUS_READ_EN
   assign stat_rd_hit = shit;
`else
   assign stat_rd_hit = 1'b0;
`endif

   assign bus.writeOut  = bus.writeIn & ~dhit & ~shit;
   assign bus.readOut   = bus.readIn & ~stat_rd_hit;
   assign bus.memOutOut = stat_rd_hit ? status : bus.memOutIn;
   assign bus.data      = data_q;
   assign bus.start     = start_q;

   assign fsync    = sync2_q;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign push_req = bus.writeIn & dhit;
   // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
   assign push_ok  = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;
   assign ovf_clr  = bus.writeIn & shit & bus.dataIn[3];

   always_comb begin
      status         = '0;
      status[0]      = empty;
      status[1]      = full;
      status[2]      = (state_q != IDLE);
      status[3]      = ovf_q;
      status[8 +: CW] = count_q;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && !fsync) begin
               pop     = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               state_d = REQ;
            end
         end
         REQ:     if (fsync)  state_d = ACK;
         ACK:     if (!fsync) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      start_d = (state_d == REQ);
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop);
      // Set wins over a clear landing on the same edge.
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         sync1_q  <= bus.finish;
         sync2_q  <= sync1_q;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.dataIn;
   end

endmodule
